// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter
//
// Shares one data memory bus between the core load/store port (port 0) and a
// secondary master (port 1, debug/DMA). At most one access is granted per
// cycle. Ties are broken round-robin against the last granted port. A granted
// access carrying lock=1 hands exclusive ownership to that port until it
// issues an unlocked access. Read data from the one-cycle-latency memory is
// steered back to the port that issued the read.
//
// Ports
//   clock, reset                 system clock, synchronous active-high reset
//   pN_req/write/lock            request, 1=write 0=read, keep ownership
//   pN_address/write_data/byte_enable   access attributes, held until gnt
//   pN_gnt                       access accepted this cycle (combinational)
//   pN_rvalid, pN_read_data      read return, one cycle after a read grant
//   mem_address/write_data/byte_enable  muxed attributes of the granted port
//   mem_read_enable/write_enable asserted only in a granted cycle
//   mem_read_data                memory read data, one cycle after read enable

module data_memory_arbiter #(
    parameter int DATA_BITS = 32
) (
    input  logic                 clock,
    input  logic                 reset,

    input  logic                 p0_req,
    input  logic                 p0_write,
    input  logic                 p0_lock,
    input  logic [DATA_BITS-1:0] p0_address,
    input  logic [31:0]          p0_write_data,
    input  logic [3:0]           p0_byte_enable,
    output logic                 p0_gnt,
    output logic                 p0_rvalid,
    output logic [31:0]          p0_read_data,

    input  logic                 p1_req,
    input  logic                 p1_write,
    input  logic                 p1_lock,
    input  logic [DATA_BITS-1:0] p1_address,
    input  logic [31:0]          p1_write_data,
    input  logic [3:0]           p1_byte_enable,
    output logic                 p1_gnt,
    output logic                 p1_rvalid,
    output logic [31:0]          p1_read_data,

    output logic [DATA_BITS-1:0] mem_address,
    output logic [31:0]          mem_write_data,
    output logic [3:0]           mem_byte_enable,
    output logic                 mem_read_enable,
    output logic                 mem_write_enable,
    input  logic [31:0]          mem_read_data
);

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t state;
    logic   owner;
    logic   last_grant;
    logic   resp_valid;
    logic   resp_port;

    logic   gnt0;
    logic   gnt1;
    logic   any_gnt;
    logic   sel_write;
    logic   sel_lock;

    // Stage 0: combinational grant and bus mux in the request cycle
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (state == LOCKED) begin
                gnt0 = p0_req & ~owner;
                gnt1 = p1_req & owner;
            end else if (p0_req && p1_req) begin
                // last_grant == 1 means port 1 went last, so port 0 wins
                gnt0 = last_grant;
                gnt1 = ~last_grant;
            end else begin
                gnt0 = p0_req;
                gnt1 = p1_req;
            end
        end
    end

    assign any_gnt   = gnt0 | gnt1;
    assign sel_write = gnt1 ? p1_write : p0_write;
    assign sel_lock  = gnt1 ? p1_lock  : p0_lock;

    assign p0_gnt = gnt0;
    assign p1_gnt = gnt1;

    // Without a grant the attribute mux rests on port 0
    assign mem_address      = gnt1 ? p1_address     : p0_address;
    assign mem_write_data   = gnt1 ? p1_write_data  : p0_write_data;
    assign mem_byte_enable  = gnt1 ? p1_byte_enable : p0_byte_enable;
    assign mem_read_enable  = any_gnt & ~sel_write;
    assign mem_write_enable = any_gnt & sel_write;

    // Stage 1: read return steered to the issuing port
    // Gating with reset drops a response whose grant preceded a reset.
    assign p0_rvalid    = resp_valid & ~reset & ~resp_port;
    assign p1_rvalid    = resp_valid & ~reset & resp_port;
    assign p0_read_data = mem_read_data;
    assign p1_read_data = mem_read_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ARB;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            resp_valid <= 1'b0;
            resp_port  <= 1'b0;
        end else begin
            resp_valid <= any_gnt & ~sel_write;
            if (any_gnt) begin
                resp_port  <= gnt1;
                last_grant <= gnt1;
                // In LOCKED only the owner is granted, so this keeps it
                owner      <= gnt1;
                state      <= sel_lock ? LOCKED : ARB;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
module tb_data_memory_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    bit          r_req [2];
    bit          r_wr  [2];
    bit          r_lk  [2];
    logic [31:0] r_addr[2];
    logic [31:0] r_wd  [2];
    logic [3:0]  r_be  [2];
    logic [31:0] mem_rd;

    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [31:0] p0_read_data, p1_read_data;
    logic [31:0] mem_address, mem_write_data;
    logic [3:0]  mem_byte_enable;
    logic        mem_read_enable, mem_write_enable;

    data_memory_arbiter #(.DATA_BITS(32)) dut (
        .clock           (clock),
        .reset           (reset),
        .p0_req          (r_req[0]),
        .p0_write        (r_wr[0]),
        .p0_lock         (r_lk[0]),
        .p0_address      (r_addr[0]),
        .p0_write_data   (r_wd[0]),
        .p0_byte_enable  (r_be[0]),
        .p0_gnt          (p0_gnt),
        .p0_rvalid       (p0_rvalid),
        .p0_read_data    (p0_read_data),
        .p1_req          (r_req[1]),
        .p1_write        (r_wr[1]),
        .p1_lock         (r_lk[1]),
        .p1_address      (r_addr[1]),
        .p1_write_data   (r_wd[1]),
        .p1_byte_enable  (r_be[1]),
        .p1_gnt          (p1_gnt),
        .p1_rvalid       (p1_rvalid),
        .p1_read_data    (p1_read_data),
        .mem_address     (mem_address),
        .mem_write_data  (mem_write_data),
        .mem_byte_enable (mem_byte_enable),
        .mem_read_enable (mem_read_enable),
        .mem_write_enable(mem_write_enable),
        .mem_read_data   (mem_rd)
    );

    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: ownership, round-robin memory and the read in flight
    bit m_locked;
    int m_owner;
    int m_last;
    int m_pend;     // port whose read returns this cycle, -1 if none
    int winner;     // port expected to be granted this cycle, -1 if none

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; moves to mid-cycle, predicts and checks outputs
    task automatic settle();
        int sel;
        #4;
        winner = -1;
        if (m_locked) begin
            if (r_req[m_owner]) winner = m_owner;
        end else if (r_req[0] && r_req[1]) begin
            winner = 1 - m_last;
        end else if (r_req[0]) begin
            winner = 0;
        end else if (r_req[1]) begin
            winner = 1;
        end
        sel = (winner == 1) ? 1 : 0;
        chk("p0_gnt", p0_gnt, winner == 0);
        chk("p1_gnt", p1_gnt, winner == 1);
        chk("mem_read_enable",  mem_read_enable,  winner >= 0 && !r_wr[sel]);
        chk("mem_write_enable", mem_write_enable, winner >= 0 && r_wr[sel]);
        chk("mem_address",      mem_address,      r_addr[sel]);
        chk("mem_write_data",   mem_write_data,   r_wd[sel]);
        chk("mem_byte_enable",  mem_byte_enable,  r_be[sel]);
        chk("p0_rvalid", p0_rvalid, m_pend == 0);
        chk("p1_rvalid", p1_rvalid, m_pend == 1);
        if (m_pend == 0) chk("p0_read_data", p0_read_data, mem_rd);
        if (m_pend == 1) chk("p1_read_data", p1_read_data, mem_rd);
    endtask

    task automatic advance();
        @(posedge clock);
        if (winner >= 0) begin
            m_last   = winner;
            m_owner  = winner;
            m_locked = r_lk[winner];
            m_pend   = r_wr[winner] ? -1 : winner;
        end else begin
            m_pend = -1;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #4;
        chk("rst_p0_gnt", p0_gnt, 1'b0);
        chk("rst_p1_gnt", p1_gnt, 1'b0);
        chk("rst_mem_re", mem_read_enable, 1'b0);
        chk("rst_mem_we", mem_write_enable, 1'b0);
        chk("rst_p0_rvalid", p0_rvalid, 1'b0);
        chk("rst_p1_rvalid", p1_rvalid, 1'b0);
        @(posedge clock);
        #1;
        reset    = 1'b0;
        m_locked = 1'b0;
        m_owner  = 0;
        m_last   = 1;
        m_pend   = -1;
    endtask

    task automatic set_port(input int p, input bit req, input bit wr, input bit lk,
                            input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        r_req[p] = req; r_wr[p] = wr; r_lk[p] = lk;
        r_addr[p] = a;  r_wd[p] = d;  r_be[p] = be;
    endtask

    task automatic idle_ports();
        set_port(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        set_port(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        int exp_seq[4];
        idle_ports();
        mem_rd = 32'h0;
        @(posedge clock);
        #1;
        do_reset();

        // Single read from port 0
        set_port(0, 1, 0, 0, 32'h8000_0010, 32'h0, 4'hF);
        settle();
        chk("sr_p0_gnt", p0_gnt, 1'b1);
        chk("sr_mem_re", mem_read_enable, 1'b1);
        chk("sr_mem_addr", mem_address, 32'h8000_0010);
        advance();
        idle_ports();
        mem_rd = 32'hDEAD_BEEF;
        settle();
        chk("sr_p0_rvalid", p0_rvalid, 1'b1);
        chk("sr_p0_data", p0_read_data, 32'hDEAD_BEEF);
        chk("sr_p1_rvalid", p1_rvalid, 1'b0);
        advance();

        // Tie from reset alternates p0, p1, p0, p1
        do_reset();
        exp_seq = '{0, 1, 0, 1};
        set_port(0, 1, 0, 0, 32'h100, 32'h0, 4'hF);
        set_port(1, 1, 0, 0, 32'h200, 32'h0, 4'hF);
        for (int i = 0; i < 4; i++) begin
            mem_rd = $urandom;
            settle();
            chk("rr_p0_gnt", p0_gnt, exp_seq[i] == 0);
            chk("rr_p1_gnt", p1_gnt, exp_seq[i] == 1);
            if (i > 0) chk("rr_rvalid_port", p1_rvalid, exp_seq[i-1] == 1);
            advance();
        end
        idle_ports();
        mem_rd = $urandom;
        settle();
        chk("rr_last_rvalid", p1_rvalid, 1'b1);
        advance();

        // Write from port 1
        set_port(1, 1, 1, 0, 32'h8000_0020, 32'h1234_5678, 4'h3);
        settle();
        chk("wr_p1_gnt", p1_gnt, 1'b1);
        chk("wr_mem_we", mem_write_enable, 1'b1);
        chk("wr_mem_be", mem_byte_enable, 4'h3);
        chk("wr_mem_wd", mem_write_data, 32'h1234_5678);
        advance();
        idle_ports();
        settle();
        chk("wr_no_rvalid", {p0_rvalid, p1_rvalid}, 2'b00);
        advance();

        // Lock: p0 locked read then unlocked write, p1 requesting throughout
        set_port(0, 1, 0, 1, 32'h300, 32'h0, 4'hF);
        set_port(1, 1, 0, 0, 32'h400, 32'h0, 4'hF);
        settle();
        chk("lk_a_p0_gnt", p0_gnt, 1'b1);
        chk("lk_a_p1_gnt", p1_gnt, 1'b0);
        advance();
        set_port(0, 1, 1, 0, 32'h300, 32'hCAFE_F00D, 4'hF);
        settle();
        chk("lk_b_p0_gnt", p0_gnt, 1'b1);
        chk("lk_b_p1_gnt", p1_gnt, 1'b0);
        advance();
        set_port(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        settle();
        chk("lk_c_p1_gnt", p1_gnt, 1'b1);
        advance();
        idle_ports();
        settle();
        advance();

        // Reset in the cycle after a locked p1 read
        set_port(1, 1, 0, 1, 32'h500, 32'h0, 4'hF);
        settle();
        chk("mr_p1_gnt", p1_gnt, 1'b1);
        advance();
        set_port(0, 1, 0, 0, 32'h600, 32'h0, 4'hF);
        set_port(1, 1, 0, 0, 32'h700, 32'h0, 4'hF);
        reset = 1'b1;
        #4;
        chk("mr_p1_rvalid", p1_rvalid, 1'b0);
        chk("mr_gnts", {p0_gnt, p1_gnt}, 2'b00);
        @(posedge clock);
        #1;
        reset = 1'b0; m_locked = 0; m_owner = 0; m_last = 1; m_pend = -1;
        settle();
        chk("mr_tie_p0", p0_gnt, 1'b1);
        advance();
        idle_ports();
        settle();
        advance();

        // Idle bus
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("idle_en", {mem_read_enable, mem_write_enable}, 2'b00);
            chk("idle_gnt_rv", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid}, 4'h0);
            advance();
        end

        // Random traffic; a request stays unchanged until granted
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!r_req[p] && ($urandom_range(0, 1) == 1))
                    set_port(p, 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                             $urandom, $urandom, 4'($urandom_range(0, 15)));
            end
            mem_rd = $urandom;
            settle();
            advance();
            if (winner >= 0) r_req[winner] = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-port round-robin arbiter that shares the single data memory bus between the core's load/store port (port 0) and a secondary master such as a debug or DMA engine (port 1). It sits between the requesters and the data memory bus. It grants at most one access per cycle and routes the memory bus's one-cycle-latency read data back to the port that issued the read. A lock mechanism holds ownership across an atomic read-modify-write sequence.

## Interface
- DATA_BITS, 32: address width carried to the memory bus.
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- p0_req, p1_req  input  1 each  access request.
- p0_write, p1_write  input  1 each  1 = write, 0 = read.
- p0_lock, p1_lock  input  1 each  keep ownership after this access.
- p0_address, p1_address  input  DATA_BITS each  byte address.
- p0_write_data, p1_write_data  input  32 each  store data.
- p0_byte_enable, p1_byte_enable  input  4 each  byte lanes.
- p0_gnt, p1_gnt  output  1 each  access accepted this cycle (combinational).
- p0_rvalid, p1_rvalid  output  1 each  read data valid (registered, one cycle after grant).
- p0_read_data, p1_read_data  output  32 each  equal to mem_read_data; qualified by rvalid.
- mem_address  output  DATA_BITS  muxed address.
- mem_write_data  output  32  muxed store data.
- mem_byte_enable  output  4  muxed lanes.
- mem_read_enable, mem_write_enable  output  1 each  asserted only in a granted cycle.
- mem_read_data  input  32  memory bus read data, valid one cycle after mem_read_enable.

## Operation
- Requesters hold req and all attributes stable until gnt. Withdrawing a request before gnt is a protocol violation; the arbiter does not have to handle it.
- State machine:
  - ARB: grant rules.
    - Only one port requests: grant that port.
    - Both request: grant the port opposite to last_grant.
    - A granted access with lock=1 moves to LOCKED, and the granted port becomes owner.
  - LOCKED: only owner can be granted; the other port's gnt stays 0.
    - An owner access granted with lock=0 returns to ARB after that access.
    - An owner access with lock=1 stays in LOCKED.
- last_grant updates to the granted port on every grant, in both states.
- Bus mux:
  - The mem_* outputs follow the granted port.
  - With no grant: mem_read_enable = mem_write_enable = 0, and mem_address, mem_write_data and mem_byte_enable follow port 0.
  - mem_read_enable = gnt & ~write.
  - mem_write_enable = gnt & write.
- Read return:
  - A granted read sets resp_valid = 1 and resp_port = granted port for the next cycle.
  - pN_rvalid = resp_valid & (resp_port == N).
  - Writes produce no rvalid.
- Back-to-back: a new grant is allowed in the same cycle as a previous read's rvalid. Throughput is one access per cycle.

## Timing
- Reset values:
  - State: ARB; last_grant = 1, so port 0 wins the first tie; resp_valid = 0.
  - Outputs: both gnt = 0 and mem enables = 0 while reset is high; both rvalid = 0 in the cycle after reset is sampled.
- gnt and mem_* are combinational from req and state, in the same cycle as req. The memory samples on the next rising edge.
- Read latency: rvalid and data arrive exactly 1 cycle after gnt.
- Reset mid-operation: reset asserted in the cycle after a granted read suppresses that rvalid. A LOCKED state is abandoned and the arbiter returns to ARB.
- Lock released with the owner idle: the owner's next non-locked access ends LOCKED. The other port can starve in the meantime; this is accepted, and requesters must keep lock sequences to ≤2 accesses.
- Simultaneous req in ARB with no lock active: exactly one gnt per cycle, never both.

## Test plan
- Single read: p0 reads 0x8000_0010 while memory returns 0xDEAD_BEEF.
  - p0_gnt is high in cycle 0 with mem_read_enable = 1 and mem_address = 0x8000_0010.
  - p0_rvalid is high in cycle 1 with data 0xDEAD_BEEF; p1_rvalid stays 0.
- Tie and round-robin: both ports hold reads for 4 cycles starting from reset.
  - Grants go p0, p1, p0, p1.
  - Each rvalid lands on the matching port one cycle after its grant.
- Write: p1 writes 0x1234_5678 to 0x8000_0020 with byte_enable 0x3.
  - mem_write_enable = 1 and mem_byte_enable = 0x3 in the grant cycle.
  - No rvalid on either port.
- Lock: p0 issues a locked read, then an unlocked write, while p1 requests continuously.
  - p1_gnt stays 0 until p0's write is granted.
  - p1 is granted in the following cycle.
- Reset mid-operation: assert reset in the cycle after a granted p1 read while in LOCKED.
  - p1_rvalid = 0 and both gnt = 0.
  - After reset releases, a p0/p1 tie grants p0.
- Idle bus: no requests for 10 cycles.
  - mem_read_enable = mem_write_enable = 0 throughout.
  - All gnt and rvalid stay 0.
